// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl -- programmable clock divider with run/stop control
//
// Generates a registered divided clock (clk_div) whose half period is div+1
// cycles of clk. The terminal count div is loaded at reset from DEFAULT_DIV
// and can be changed through a valid/ready configuration port. While running,
// a new count is held pending and applied only at the next terminal count so
// that no half period is ever cut short. A stop request lets the current high
// phase finish, so clk_div always returns to 0 cleanly.
//
// Optional feature:
//   DIV_CTRL_PERIOD_CNT_EN  when defined, 'periods' counts completed full
//                           clk_div periods (saturating at 16'hFFFF); when
//                           undefined, 'periods' is tied to 0 and no counter
//                           register exists.
//
// Parameters:
//   W            width of the divide count
//   DEFAULT_DIV  terminal count loaded at reset
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous reset, active low
//   start      in   run request, sampled only in IDLE
//   stop       in   stop request, sampled only in RUN
//   cfg_valid  in   qualifies cfg_div
//   cfg_div    in   new terminal count (0 is rejected with cfg_err)
//   cfg_ready  out  a cfg word can be accepted this cycle
//   clk_div    out  divided clock (registered)
//   tick       out  one-cycle pulse coincident with every clk_div toggle
//   busy       out  high in RUN or STOPPING
//   cfg_err    out  one-cycle pulse after a cfg_div==0 word is consumed
//   periods    out  completed full clk_div periods
// -----------------------------------------------------------------------------
module div_ctrl #(
    parameter int W           = 26,
    parameter int DEFAULT_DIV = 25000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         clk_div,
    output logic         tick,
    output logic         busy,
    output logic         cfg_err,
    output logic [15:0]  periods
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [W-1:0] DIV_RST = W'(DEFAULT_DIV);

    state_t       state, state_n;
    logic [W-1:0] cnt, cnt_n;
    logic [W-1:0] div, div_n;
    logic [W-1:0] pend_div, pend_div_n;
    logic         pend_valid, pend_valid_n;
    logic         clk_div_n;
    logic         tick_n;
    logic         cfg_err_n;

    logic         accept;   // cfg handshake completes this cycle
    logic         cfg_ok;   // accepted word is usable (non-zero)
    logic         tc;       // terminal count reached

    // In IDLE a word goes straight into div; while running only one word
    // may wait for the next terminal count.
    assign cfg_ready = (state == IDLE) || !pend_valid;
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_ok    = accept && (cfg_div != '0);
    assign tc        = (cnt == div);
    assign busy      = (state != IDLE);

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned -- otherwise synthesis infers a latch.
        state_n      = state;
        cnt_n        = cnt;
        div_n        = div;
        pend_div_n   = pend_div;
        pend_valid_n = pend_valid;
        clk_div_n    = clk_div;
        tick_n       = 1'b0;
        cfg_err_n    = accept && (cfg_div == '0);

        unique case (state)
            IDLE: begin
                clk_div_n = 1'b0;
                if (cfg_ok) begin
                    div_n = cfg_div;
                end
                if (start) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            end

            RUN, STOPPING: begin
                if ((state == RUN) && stop && !clk_div) begin
                    // Already low: leave at once without counting or toggling.
                    // A waiting word is applied on the way into IDLE.
                    state_n = IDLE;
                    if (pend_valid) begin
                        div_n        = pend_div;
                        pend_valid_n = 1'b0;
                    end
                    if (cfg_ok) begin
                        div_n = cfg_div;
                    end
                end else begin
                    if ((state == RUN) && stop) begin
                        state_n = STOPPING;
                    end

                    if (tc) begin
                        cnt_n     = '0;
                        clk_div_n = !clk_div;
                        tick_n    = 1'b1;
                        if (pend_valid) begin
                            div_n        = pend_div;
                            pend_valid_n = 1'b0;
                        end
                        // The falling toggle ends a stop request, including
                        // one sampled in this very cycle.
                        if (clk_div && ((state == STOPPING) || stop)) begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + W'(1);
                    end

                    // A word accepted alongside the terminal count waits for
                    // the next one, unless the run is ending now.
                    if (cfg_ok) begin
                        if (state_n == IDLE) begin
                            div_n = cfg_div;
                        end else begin
                            pend_valid_n = 1'b1;
                            pend_div_n   = cfg_div;
                        end
                    end
                end
            end

            default: begin
                state_n   = IDLE;
                clk_div_n = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            div        <= DIV_RST;
            pend_div   <= '0;
            pend_valid <= 1'b0;
            clk_div    <= 1'b0;
            tick       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, independent of statement order.
            state      <= state_n;
            cnt        <= cnt_n;
            div        <= div_n;
            pend_div   <= pend_div_n;
            pend_valid <= pend_valid_n;
            clk_div    <= clk_div_n;
            tick       <= tick_n;
            cfg_err    <= cfg_err_n;
        end
    end

    // -------------------------------------------------------------------------
    // Completed-period counter: counts 1->0 toggles, saturating
    // -------------------------------------------------------------------------
`ifdef DIV_CTRL_PERIOD_CNT_EN
    logic [15:0] period_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt <= '0;
        end else if (tick_n && clk_div && (period_cnt != 16'hFFFF)) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end

    assign periods = period_cnt;
`else
    assign periods = '0;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl -- self-checking bench for div_ctrl (W=8, DEFAULT_DIV=5)
//
// A cycle-by-cycle vector table covers start, the div+1 half period, a
// pending reconfiguration, a rejected zero word, stop while high and stop
// while low. Hand-written sequences cover a reset with a word pending,
// start with a coincident cfg word, and the completed-period counter.
// Expected periods values follow DIV_CTRL_PERIOD_CNT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_div_ctrl;

    localparam int W = 8;

`ifdef DIV_CTRL_PERIOD_CNT_EN
    localparam bit PCNT = 1'b1;
`else
    localparam bit PCNT = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;
    logic         clk_div;
    logic         tick;
    logic         busy;
    logic         cfg_err;
    logic [15:0]  periods;

    div_ctrl #(
        .W           (W),
        .DEFAULT_DIV (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_div   (clk_div),
        .tick      (tick),
        .busy      (busy),
        .cfg_err   (cfg_err),
        .periods   (periods)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_per(input logic [15:0] p);
        return PCNT ? p : 16'd0;
    endfunction

    typedef struct {
        logic         start;
        logic         stop;
        logic         cfg_valid;
        logic [W-1:0] cfg_div;
        logic         clk_div;
        logic         tick;
        logic         busy;
        logic         cfg_ready;
        logic         cfg_err;
        logic [15:0]  periods;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int st, input int sp, input int cv, input int cd,
                       input int eclk, input int etick, input int ebusy,
                       input int erdy, input int eerr, input int eper);
        vec_t v;
        v.start     = (st != 0);
        v.stop      = (sp != 0);
        v.cfg_valid = (cv != 0);
        v.cfg_div   = W'(cd);
        v.clk_div   = (eclk != 0);
        v.tick      = (etick != 0);
        v.busy      = (ebusy != 0);
        v.cfg_ready = (erdy != 0);
        v.cfg_err   = (eerr != 0);
        v.periods   = 16'(eper);
        vecs.push_back(v);
    endtask

    // Counts edges until tick is seen (bounded); returns the edge count.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((tick !== 1'b1) && (n < 50));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ticks;
        int first;

        // Columns: start stop cfg_valid cfg_div | clk_div tick busy cfg_ready cfg_err periods
        // Each row is applied for one edge; expectations are post-edge values.
        add(0,0,1,3, 0,0,0,1,0,0);  // r0  load div=3 in IDLE
        add(1,0,0,0, 0,0,1,1,0,0);  // r1  start, cnt cleared
        add(0,0,0,0, 0,0,1,1,0,0);  // r2
        add(0,0,0,0, 0,0,1,1,0,0);  // r3
        add(0,0,0,0, 0,0,1,1,0,0);  // r4
        add(0,0,0,0, 1,1,1,1,0,0);  // r5  first toggle, 4 edges after start
        add(0,0,0,0, 1,0,1,1,0,0);  // r6
        add(0,0,0,0, 1,0,1,1,0,0);  // r7
        add(0,0,0,0, 1,0,1,1,0,0);  // r8
        add(0,0,0,0, 0,1,1,1,0,1);  // r9  falling toggle, period 1
        add(0,0,0,0, 0,0,1,1,0,1);  // r10
        add(0,0,1,1, 0,0,1,0,0,1);  // r11 cfg_div=1 mid half period -> pending
        add(0,0,0,0, 0,0,1,0,0,1);  // r12 still pending
        add(0,0,0,0, 1,1,1,1,0,1);  // r13 full 4-edge half period, then apply
        add(0,0,0,0, 1,0,1,1,0,1);  // r14
        add(0,0,0,0, 0,1,1,1,0,2);  // r15 2-edge half periods now
        add(0,0,0,0, 0,0,1,1,0,2);  // r16
        add(0,0,0,0, 1,1,1,1,0,2);  // r17
        add(0,0,1,0, 1,0,1,1,1,2);  // r18 zero word -> cfg_err
        add(0,0,0,0, 0,1,1,1,0,3);  // r19 period unchanged
        add(0,0,0,0, 0,0,1,1,0,3);  // r20
        add(0,0,0,0, 1,1,1,1,0,3);  // r21
        add(0,1,0,0, 1,0,1,1,0,3);  // r22 stop while high -> STOPPING
        add(0,0,0,0, 0,1,0,1,0,4);  // r23 falls at terminal count, IDLE
        add(0,0,0,0, 0,0,0,1,0,4);  // r24 no further ticks
        add(0,0,0,0, 0,0,0,1,0,4);  // r25
        add(0,0,0,0, 0,0,0,1,0,4);  // r26
        add(1,0,0,0, 0,0,1,1,0,4);  // r27 restart at div=1
        add(0,0,0,0, 0,0,1,1,0,4);  // r28
        add(0,0,0,0, 1,1,1,1,0,4);  // r29
        add(0,0,0,0, 1,0,1,1,0,4);  // r30
        add(0,0,0,0, 0,1,1,1,0,5);  // r31
        add(0,0,1,4, 0,0,1,0,0,5);  // r32 cfg_div=4 pending
        add(0,1,0,0, 0,0,0,1,0,5);  // r33 stop while low -> IDLE, no toggle
        add(1,0,0,0, 0,0,1,1,0,5);  // r34 restart: pending word now in div
        add(0,0,0,0, 0,0,1,1,0,5);  // r35
        add(0,0,0,0, 0,0,1,1,0,5);  // r36
        add(0,0,0,0, 0,0,1,1,0,5);  // r37
        add(0,0,0,0, 0,0,1,1,0,5);  // r38
        add(0,0,0,0, 1,1,1,1,0,5);  // r39 5-edge half period (div=4)

        // ---------------- reset ----------------
        rst       = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        #2;
        check("reset clk_div", 32'(clk_div), 32'd0);
        check("reset tick",    32'(tick),    32'd0);
        check("reset busy",    32'(busy),    32'd0);
        check("reset cfg_err", 32'(cfg_err), 32'd0);
        check("reset periods", 32'(periods), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset cfg_ready", 32'(cfg_ready), 32'd1);

        // ---------------- vector table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            start     = vecs[i].start;
            stop      = vecs[i].stop;
            cfg_valid = vecs[i].cfg_valid;
            cfg_div   = vecs[i].cfg_div;
            @(posedge clk);
            #1;
            check($sformatf("row%0d clk_div", i),   32'(clk_div),   32'(vecs[i].clk_div));
            check($sformatf("row%0d tick", i),      32'(tick),      32'(vecs[i].tick));
            check($sformatf("row%0d busy", i),      32'(busy),      32'(vecs[i].busy));
            check($sformatf("row%0d cfg_ready", i), 32'(cfg_ready), 32'(vecs[i].cfg_ready));
            check($sformatf("row%0d cfg_err", i),   32'(cfg_err),   32'(vecs[i].cfg_err));
            check($sformatf("row%0d periods", i),   32'(periods),   32'(exp_per(vecs[i].periods)));
        end
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;

        // ---------------- reset mid-half-period with a word pending ----------------
        cfg_valid = 1'b1;
        cfg_div   = W'(2);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        check("pending cfg_ready", 32'(cfg_ready), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst clk_div",   32'(clk_div),   32'd0);
        check("midrst tick",      32'(tick),      32'd0);
        check("midrst busy",      32'(busy),      32'd0);
        check("midrst cfg_err",   32'(cfg_err),   32'd0);
        check("midrst periods",   32'(periods),   32'd0);
        check("midrst cfg_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("restart cfg_ready", 32'(cfg_ready), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart busy", 32'(busy), 32'd1);
        wait_tick(n);
        check("restart 1st half edges", 32'(n), 32'd6);
        check("restart 1st half clk_div", 32'(clk_div), 32'd1);
        wait_tick(n);
        check("restart 2nd half edges", 32'(n), 32'd6);
        check("restart 2nd half clk_div", 32'(clk_div), 32'd0);

        // ---------------- start + cfg together, period counter ----------------
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("pc reset periods", 32'(periods), 32'd0);
        start     = 1'b1;
        cfg_valid = 1'b1;
        cfg_div   = W'(2);
        @(posedge clk);
        #1;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        ticks = 0;
        first = 0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            if (tick === 1'b1) begin
                ticks++;
                if (first == 0) first = k;
            end
        end
        check("pc first toggle edge", 32'(first), 32'd3);
        check("pc tick count", 32'(ticks), 32'd6);
        check("pc clk_div", 32'(clk_div), 32'd0);
        check("pc periods after 3", 32'(periods), 32'(exp_per(16'd3)));
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pc periods mid 4th", 32'(periods), 32'(exp_per(16'd3)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
